// File: rtl/mealy_out_packer_if.sv
// mealy_out_packer_if: serial bit input and packed-word valid/ready bundle for mealy_out_packer
interface mealy_out_packer_if #(parameter int WORD_W = 8);
  logic bit_in, bit_vld, flush, word_rdy;
  logic [2:0] state_in;
  logic [WORD_W-1:0] word_out;
  logic word_vld, word_partial, ovf;
  logic [2:0] word_tag;
  logic [$clog2(WORD_W+1)-1:0] bit_cnt;
  modport master (output bit_in, bit_vld, state_in, flush, word_rdy,
                  input word_out, word_vld, word_partial, word_tag, bit_cnt, ovf);
  modport slave (input bit_in, bit_vld, state_in, flush, word_rdy,
                 output word_out, word_vld, word_partial, word_tag, bit_cnt, ovf);
endinterface

// File: rtl/mealy_out_packer.sv
// mealy_out_packer: packs the Mealy FSM bit stream into WORD_W-bit words (one output + one pending slot).
// Optional STATE_TAG_EN macro carries the state code of each word's first bit onto word_tag.
module mealy_out_packer #(
  parameter int WORD_W = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst_n,
  mealy_out_packer_if.slave io
);
  localparam int CW = $clog2(WORD_W+1);
  localparam logic [CW-1:0] W_C = CW'(WORD_W);
  typedef enum logic {FILL, PEND} state_t;
  state_t state_q, state_d;
  logic [WORD_W-1:0] sh_q, sh_d, sh_n, word_q, word_d, pend_q, pend_d, done_w;
  logic [CW-1:0] cnt_q, cnt_d, cnt_n;
  logic vld_q, vld_d, part_q, part_d, ppart_q, ppart_d, ovf_q, ovf_d;
  logic slot_free, acc, full, fl;
  always_comb begin
    slot_free = !vld_q || io.word_rdy;
    acc = io.bit_vld && (state_q == FILL || io.word_rdy);
    sh_n = MSB_FIRST ? {sh_q[WORD_W-2:0], io.bit_in} : {io.bit_in, sh_q[WORD_W-1:1]};
    sh_d = acc ? sh_n : sh_q;
    full = acc && state_q == FILL && cnt_q == W_C - 1'b1;
    fl = io.flush && state_q == FILL && cnt_q != '0 && !full;
    cnt_n = cnt_q + CW'(acc);
    // zero padding: push the received bits to the first-bit end of the word
    done_w = MSB_FIRST ? sh_d << (W_C - cnt_n) : sh_d >> (W_C - cnt_n);
    state_d = state_q;
    cnt_d = cnt_q;
    word_d = word_q;
    pend_d = pend_q;
    part_d = part_q;
    ppart_d = ppart_q;
    ovf_d = ovf_q;
    vld_d = vld_q && !io.word_rdy;
    if (state_q == FILL) begin
      cnt_d = cnt_n;
      if (full || fl) begin
        if (slot_free) begin
          word_d = done_w;
          part_d = fl;
          vld_d = 1'b1;
          cnt_d = '0;
        end else begin
          pend_d = done_w;
          ppart_d = fl;
          cnt_d = W_C;
          state_d = PEND;
        end
      end
    end else if (io.word_rdy) begin
      word_d = pend_q;
      part_d = ppart_q;
      vld_d = 1'b1;
      cnt_d = CW'(io.bit_vld);
      state_d = FILL;
    end else begin
      ovf_d = ovf_q || io.bit_vld;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      sh_q <= '0;
      cnt_q <= '0;
      word_q <= '0;
      pend_q <= '0;
      vld_q <= 1'b0;
      part_q <= 1'b0;
      ppart_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      word_q <= word_d;
      pend_q <= pend_d;
      vld_q <= vld_d;
      part_q <= part_d;
      ppart_q <= ppart_d;
      ovf_q <= ovf_d;
    end
  end
`ifdef STATE_TAG_EN
  logic [2:0] tag_q, tag_d, wtag_q, wtag_d, ptag_q, ptag_d;
  always_comb begin
    tag_d = (acc && (state_q == PEND || cnt_q == '0)) ? io.state_in : tag_q;
    wtag_d = wtag_q;
    ptag_d = ptag_q;
    if (state_q == FILL && (full || fl)) begin
      if (slot_free) wtag_d = tag_q;
      else ptag_d = tag_q;
    end else if (state_q == PEND && io.word_rdy) begin
      wtag_d = ptag_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
      wtag_q <= '0;
      ptag_q <= '0;
    end else begin
      tag_q <= tag_d;
      wtag_q <= wtag_d;
      ptag_q <= ptag_d;
    end
  end
  assign io.word_tag = wtag_q;
`else
  logic unused_state;
  assign unused_state = ^io.state_in;
  assign io.word_tag = 3'b000;
`endif
  assign io.word_out = word_q;
  assign io.word_vld = vld_q;
  assign io.word_partial = part_q;
  assign io.bit_cnt = cnt_q;
  assign io.ovf = ovf_q;
endmodule

// File: tb/tb_mealy_out_packer.sv
// tb_mealy_out_packer: MSB-first and LSB-first packers driven in lockstep, checked against a bit-queue model.
module tb_mealy_out_packer;
  localparam int W = 8;
  typedef struct {logic [W-1:0] m; logic [W-1:0] l; bit p; logic [2:0] t;} wrd_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic bit_in = 1'b0, bit_vld = 1'b0, flush = 1'b0, word_rdy = 1'b0;
  logic [2:0] state_in = 3'b000;
  int errors = 0, checks = 0;
  bit m_bits[$];
  wrd_t m_out[$];
  logic [2:0] m_tag;
  bit m_ovf;
  mealy_out_packer_if #(.WORD_W(W)) ifm ();
  mealy_out_packer_if #(.WORD_W(W)) ifl ();
  assign ifm.bit_in = bit_in;
  assign ifm.bit_vld = bit_vld;
  assign ifm.state_in = state_in;
  assign ifm.flush = flush;
  assign ifm.word_rdy = word_rdy;
  assign ifl.bit_in = bit_in;
  assign ifl.bit_vld = bit_vld;
  assign ifl.state_in = state_in;
  assign ifl.flush = flush;
  assign ifl.word_rdy = word_rdy;
  mealy_out_packer #(.WORD_W(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .io(ifm));
  mealy_out_packer #(.WORD_W(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .io(ifl));
  always #5 clk = ~clk;

  function automatic logic [2:0] texp(input logic [2:0] t);
`ifdef STATE_TAG_EN
    return t;
`else
    return 3'b000;
`endif
  endfunction

  function automatic wrd_t make_word(input bit partial);
    wrd_t w;
    w.m = '0;
    w.l = '0;
    for (int i = 0; i < m_bits.size(); i++) begin
      w.m[W-1-i] = m_bits[i];
      w.l[i] = m_bits[i];
    end
    w.p = partial;
    w.t = m_tag;
    return w;
  endfunction

  task automatic model_edge(input bit b, v, input logic [2:0] st, input bit fl, rdy);
    bit had;
    if (m_out.size() == 2) begin
      if (rdy) begin
        void'(m_out.pop_front());
        m_bits.delete();
        if (v) begin
          m_bits.push_back(b);
          m_tag = st;
        end
      end else if (v) m_ovf = 1'b1;
    end else begin
      had = m_bits.size() > 0;
      if (m_out.size() > 0 && rdy) void'(m_out.pop_front());
      if (v) begin
        if (m_bits.size() == 0) m_tag = st;
        m_bits.push_back(b);
      end
      if (m_bits.size() == W || (fl && had)) begin
        m_out.push_back(make_word(m_bits.size() != W));
        m_bits.delete();
      end
    end
  endtask

  function automatic int exp_cnt();
    return (m_out.size() == 2) ? W : m_bits.size();
  endfunction

  task automatic step(input bit b, v, input logic [2:0] st, input bit fl, rdy);
    bit_in = b;
    bit_vld = v;
    state_in = st;
    flush = fl;
    word_rdy = rdy;
    @(posedge clk);
    model_edge(b, v, st, fl, rdy);
    @(negedge clk);
    bit_vld = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    m_bits.delete();
    m_out.delete();
    m_ovf = 1'b0;
    m_tag = 3'b000;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ifm.word_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", ifm.word_vld); end
    checks++; if (ifm.bit_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", ifm.bit_cnt); end
    checks++; if (ifm.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ifm.ovf); end
    checks++; if (ifm.word_out !== 8'h00) begin errors++; $display("FAIL reset_word got=%h exp=00", ifm.word_out); end
  endtask

  task automatic test_pack_order();
    logic [7:0] pat = 8'hB2;
    for (int i = 7; i >= 0; i--) begin
      step(pat[i], 1'b1, 3'd0, 1'b0, 1'b1);
      if (i == 1) begin
        checks++; if (ifm.word_vld !== 1'b0) begin errors++; $display("FAIL early_vld got=%b exp=0", ifm.word_vld); end
      end
    end
    checks++; if (ifm.word_vld !== 1'b1) begin errors++; $display("FAIL pack_vld got=%b exp=1", ifm.word_vld); end
    checks++; if (ifm.word_out !== 8'hB2) begin errors++; $display("FAIL msb_word got=%h exp=b2", ifm.word_out); end
    checks++; if (ifl.word_out !== 8'h4D) begin errors++; $display("FAIL lsb_word got=%h exp=4d", ifl.word_out); end
    checks++; if (ifm.word_partial !== 1'b0) begin errors++; $display("FAIL pack_partial got=%b exp=0", ifm.word_partial); end
    checks++; if (ifm.bit_cnt !== 4'd0) begin errors++; $display("FAIL pack_cnt got=%0d exp=0", ifm.bit_cnt); end
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    checks++; if (ifm.word_vld !== 1'b0) begin errors++; $display("FAIL pack_drop_vld got=%b exp=0", ifm.word_vld); end
  endtask

  task automatic test_overflow();
    logic [7:0] a = 8'hA5, c = 8'h3C;
    for (int i = 7; i >= 0; i--) step(a[i], 1'b1, 3'd0, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) step(c[i], 1'b1, 3'd0, 1'b0, 1'b0);
    checks++; if (ifm.bit_cnt !== 4'd8) begin errors++; $display("FAIL pend_cnt got=%0d exp=8", ifm.bit_cnt); end
    checks++; if (ifm.ovf !== 1'b0) begin errors++; $display("FAIL pend_ovf_early got=%b exp=0", ifm.ovf); end
    step(1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    checks++; if (ifm.word_out !== 8'hA5) begin errors++; $display("FAIL hold_word got=%h exp=a5", ifm.word_out); end
    checks++; if (ifm.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ifm.ovf); end
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    checks++; if (ifm.word_out !== 8'h3C || ifm.word_vld !== 1'b1) begin errors++; $display("FAIL drain_word got=%h/%b exp=3c/1", ifm.word_out, ifm.word_vld); end
    checks++; if (ifm.bit_cnt !== 4'd0) begin errors++; $display("FAIL drain_cnt got=%0d exp=0", ifm.bit_cnt); end
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    checks++; if (ifm.word_vld !== 1'b0 || ifm.ovf !== 1'b1) begin errors++; $display("FAIL after_drain vld/ovf got=%b/%b exp=0/1", ifm.word_vld, ifm.ovf); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ifm.bit_cnt !== 4'd0 || ifm.ovf !== 1'b0 || ifm.word_vld !== 1'b0) begin
      errors++; $display("FAIL async_rst cnt/ovf/vld got=%0d/%b/%b exp=0/0/0", ifm.bit_cnt, ifm.ovf, ifm.word_vld);
    end
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 3'd0, 1'b0, 1'b1);
    checks++; if (ifm.word_out !== 8'hFF || ifm.word_vld !== 1'b1) begin errors++; $display("FAIL post_rst_word got=%h/%b exp=ff/1", ifm.word_out, ifm.word_vld); end
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
    checks++; if (ifm.word_out !== 8'hE0 || ifm.word_partial !== 1'b1) begin errors++; $display("FAIL flush_msb got=%h/%b exp=e0/1", ifm.word_out, ifm.word_partial); end
    checks++; if (ifl.word_out !== 8'h07) begin errors++; $display("FAIL flush_lsb got=%h exp=07", ifl.word_out); end
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
    checks++; if (ifm.word_vld !== 1'b0) begin errors++; $display("FAIL empty_flush got=%b exp=0", ifm.word_vld); end
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 3'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 3'd0, 1'b1, 1'b1);
    checks++; if (ifm.word_out !== 8'hFE || ifm.word_partial !== 1'b0) begin errors++; $display("FAIL flush_full got=%h/%b exp=fe/0", ifm.word_out, ifm.word_partial); end
    checks++; if (ifl.word_out !== 8'h7F) begin errors++; $display("FAIL flush_full_lsb got=%h exp=7f", ifl.word_out); end
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
  endtask

  task automatic test_tag();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, (i == 0) ? 3'b010 : 3'b100, 1'b0, 1'b1);
    checks++; if (ifm.word_tag !== texp(3'b010)) begin errors++; $display("FAIL tag_full got=%b exp=%b", ifm.word_tag, texp(3'b010)); end
    step(1'b1, 1'b1, 3'b101, 1'b0, 1'b1);
    step(1'b0, 1'b1, 3'b001, 1'b0, 1'b1);
    step(1'b0, 1'b0, 3'b011, 1'b1, 1'b1);
    checks++; if (ifm.word_tag !== texp(3'b101) || ifm.word_out !== 8'h80) begin errors++; $display("FAIL tag_flush got=%b/%h exp=%b/80", ifm.word_tag, ifm.word_out, texp(3'b101)); end
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    bit ev;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      step(1'($urandom), $urandom_range(0, 9) < 7, 3'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 9) < ((c / 300) % 2 ? 8 : 4));
      ev = m_out.size() > 0;
      checks++; if (ifm.word_vld !== ev || ifl.word_vld !== ev) begin errors++; $display("FAIL rnd_vld cyc=%0d got=%b/%b exp=%b", c, ifm.word_vld, ifl.word_vld, ev); end
      checks++; if (ifm.bit_cnt !== 4'(exp_cnt())) begin errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, ifm.bit_cnt, exp_cnt()); end
      checks++; if (ifm.ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", c, ifm.ovf, m_ovf); end
      if (ev) begin
        checks++; if (ifm.word_out !== m_out[0].m || ifl.word_out !== m_out[0].l) begin
          errors++; $display("FAIL rnd_word cyc=%0d got=%h/%h exp=%h/%h", c, ifm.word_out, ifl.word_out, m_out[0].m, m_out[0].l);
        end
        checks++; if (ifm.word_partial !== m_out[0].p || ifm.word_tag !== texp(m_out[0].t)) begin
          errors++; $display("FAIL rnd_meta cyc=%0d got=%b/%b exp=%b/%b", c, ifm.word_partial, ifm.word_tag, m_out[0].p, texp(m_out[0].t));
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_pack_order();
    test_overflow();
    test_async_reset();
    test_flush();
    test_tag();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
